// File: rtl/product_term_configuration_encoder_pkg.sv
// rtl/product_term_configuration_encoder_pkg.sv - shared geometry, FSM states and row-index helpers
package product_term_configuration_encoder_pkg;

    localparam int DEF_NUM_LABS                    = 2;
    localparam int DEF_MACROCELLS_PER_LAB          = 16;
    localparam int DEF_PRODUCT_TERMS_PER_MACROCELL = 5;
    localparam int DEF_BITS_PER_PRODUCT_TERM       = 88;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    function automatic int calc_num_rows(int labs, int macrocells, int product_terms);
        return labs * macrocells * product_terms;
    endfunction

    function automatic int calc_row_w(int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // lab is 0-based (LAB A = 0); macrocell and product_term are 1-based as printed in the datasheet
    function automatic int row_index(int lab, int macrocell, int product_term,
                                     int macrocells, int product_terms);
        return lab * macrocells * product_terms + (macrocell - 1) * product_terms + (product_term - 1);
    endfunction

endpackage

// File: rtl/product_term_row_serializer.sv
// rtl/product_term_row_serializer.sv - loads one encoded row and shifts it out LSB first under valid/ready
module product_term_row_serializer #(
    parameter  int width = 88,
    localparam int cnt_w = (width > 1) ? $clog2(width) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [width-1:0] load_data,
    input  logic             bit_ready,
    output logic             bit_valid,
    output logic             bit_data,
    output logic             row_done
);

    logic [width-1:0] sreg_q;
    logic [cnt_w-1:0] cnt_q;
    logic             valid_q;

    assign row_done  = valid_q & bit_ready & (cnt_q == cnt_w'(width - 1));
    assign bit_valid = valid_q;
    // Gate with valid so the idle output stays at its reset value
    assign bit_data  = valid_q & sreg_q[0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            sreg_q  <= load_data;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && bit_ready) begin
            sreg_q <= sreg_q >> 1;
            if (row_done) begin
                cnt_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/product_term_configuration_encoder.sv
// rtl/product_term_configuration_encoder.sv - encodes product-term enable records into a serial config bitstream
module product_term_configuration_encoder
    import product_term_configuration_encoder_pkg::*;
#(
    parameter  int num_labs                    = DEF_NUM_LABS,
    parameter  int macrocells_per_lab          = DEF_MACROCELLS_PER_LAB,
    parameter  int product_terms_per_macrocell = DEF_PRODUCT_TERMS_PER_MACROCELL,
    parameter  int bits_per_product_term       = DEF_BITS_PER_PRODUCT_TERM,
    localparam int num_rows = calc_num_rows(num_labs, macrocells_per_lab, product_terms_per_macrocell),
    localparam int row_w    = calc_row_w(num_rows)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             term_valid,
    output logic                             term_ready,
    input  logic [row_w-1:0]                 term_index,
    input  logic [bits_per_product_term-1:0] term_enable,
    input  logic                             term_last,
    output logic                             bit_valid,
    input  logic                             bit_ready,
    output logic                             bit_data,
    output logic                             busy,
    output logic                             done,
    output logic                             order_error
);

    state_e                           state_q, state_d;
    logic [row_w-1:0]                 row_q, row_d;
    logic                             fill_q, fill_d;
    logic                             order_error_q, order_error_d;
    logic                             ser_load;
    logic [bits_per_product_term-1:0] ser_data;
    logic                             row_done;

    product_term_row_serializer #(
        .width(bits_per_product_term)
    ) u_serializer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (ser_load),
        .load_data(ser_data),
        .bit_ready(bit_ready),
        .bit_valid(bit_valid),
        .bit_data (bit_data),
        .row_done (row_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            fill_q        <= 1'b0;
            order_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            fill_q        <= fill_d;
            order_error_q <= order_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        fill_d        = fill_q;
        order_error_d = order_error_q;
        term_ready    = 1'b0;
        ser_load      = 1'b0;
        ser_data      = '1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    row_d         = '0;
                    fill_d        = 1'b0;
                    order_error_d = 1'b0;
                end
            end
            ST_LOAD: begin
                // A record ahead of the current row leaves the row unprogrammed (all ones) and stays pending
                if (fill_q) begin
                    ser_load = 1'b1;
                    state_d  = ST_SHIFT;
                end else if (term_valid) begin
                    if (term_index == row_q) begin
                        term_ready = 1'b1;
                        ser_load   = 1'b1;
                        ser_data   = ~term_enable;
                        fill_d     = term_last;
                        state_d    = ST_SHIFT;
                    end else if (term_index > row_q) begin
                        ser_load = 1'b1;
                        state_d  = ST_SHIFT;
                    end else begin
                        term_ready    = 1'b1;
                        order_error_d = 1'b1;
                        if (term_last) begin
                            fill_d = 1'b1;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                if (row_done) begin
                    if (row_q == row_w'(num_rows - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign order_error = order_error_q;

endmodule

// File: tb/tb_product_term_configuration_encoder.sv
// tb/tb_product_term_configuration_encoder.sv - self-checking bench for product_term_configuration_encoder
module tb_product_term_configuration_encoder;

    localparam int NB = 88;
    localparam int NR = 160;
    localparam int NBITS = NR * NB;

    typedef struct {
        logic [7:0]    idx;
        logic [NB-1:0] en;
        logic          last;
    } rec_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          term_valid;
    logic          term_ready;
    logic [7:0]    term_index;
    logic [NB-1:0] term_enable;
    logic          term_last;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_data;
    logic          busy;
    logic          done;
    logic          order_error;

    always #5 clock = ~clock;

    product_term_configuration_encoder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_index (term_index),
        .term_enable(term_enable),
        .term_last  (term_last),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_data   (bit_data),
        .busy       (busy),
        .done       (done),
        .order_error(order_error)
    );

    int   vectors = 0;
    int   miscompares = 0;
    rec_t rec_q[$];
    rec_t blk_q[$];
    bit   got_q[$];
    bit   exp_s[NBITS];
    bit   exp_err;
    int   step_n;
    int   done_seen;
    int   done_step;
    int   last_bit_step;
    int   ready_mode;
    logic start_req;
    bit   stall_pend;
    logic stall_bit;

    // Drive at negedge, sample 1ns later: every handshake then resolves at the following posedge
    task automatic step();
        @(negedge clock);
        start = start_req;
        case (ready_mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = ~bit_ready;
            default: bit_ready = ($urandom_range(0, 9) != 0);
        endcase
        if (rec_q.size() > 0) begin
            term_valid  = 1'b1;
            term_index  = rec_q[0].idx;
            term_enable = rec_q[0].en;
            term_last   = rec_q[0].last;
        end else begin
            term_valid  = 1'b0;
            term_index  = '0;
            term_enable = '0;
            term_last   = 1'b0;
        end
        #1;
        step_n++;
        if (stall_pend) begin
            vectors++;
            if (bit_valid !== 1'b1 || bit_data !== stall_bit) begin
                miscompares++;
                $display("FAIL stall_hold: step %0d got valid=%b data=%b required valid=1 data=%b",
                         step_n, bit_valid, bit_data, stall_bit);
            end
            stall_pend = 0;
        end
        if (bit_valid === 1'b1 && bit_ready === 1'b0) begin
            stall_pend = 1;
            stall_bit  = bit_data;
        end
        if (bit_valid === 1'b1 && bit_ready === 1'b1) begin
            got_q.push_back(bit_data);
            last_bit_step = step_n;
        end
        if (term_valid === 1'b1 && term_ready === 1'b1) begin
            void'(rec_q.pop_front());
        end
        if (done === 1'b1) begin
            done_seen++;
            done_step = step_n;
        end
    endtask

    // Reference: walk the record list as a configuration image; unprogrammed rows stay all ones
    task automatic model_block();
        int r;
        bit fill;
        int idx;
        for (int i = 0; i < NBITS; i++) exp_s[i] = 1'b1;
        exp_err = 0;
        r = 0;
        fill = 0;
        for (int k = 0; k < blk_q.size(); k++) begin
            if (fill || r >= NR) break;
            idx = int'(blk_q[k].idx);
            if (idx < r) begin
                exp_err = 1;
                if (blk_q[k].last) fill = 1;
            end else if (idx >= NR) begin
                break;
            end else begin
                for (int i = 0; i < NB; i++) exp_s[idx * NB + i] = !blk_q[k].en[i];
                r = idx + 1;
                if (blk_q[k].last) fill = 1;
            end
        end
    endtask

    task automatic run_block(input string name, input int budget, input int exp_done_step, input bit spam);
        int mism;
        int first;
        model_block();
        rec_q = blk_q;
        got_q.delete();
        done_seen = 0;
        done_step = -1;
        last_bit_step = -1;
        step_n = 0;
        start_req = 1'b1;
        step();
        while (done_seen == 0 && step_n < budget) begin
            start_req = spam && (step_n % 997 == 300);
            step();
        end
        start_req = 1'b0;
        vectors++;
        if (done_seen == 0) begin
            miscompares++;
            $display("FAIL %s_timeout: got no done in %0d cycles required done", name, budget);
        end
        vectors++;
        if (got_q.size() != NBITS) begin
            miscompares++;
            $display("FAIL %s_len: got %0d bits required %0d", name, got_q.size(), NBITS);
        end
        mism = 0;
        first = -1;
        for (int i = 0; i < got_q.size() && i < NBITS; i++) begin
            if (got_q[i] !== exp_s[i]) begin
                if (first < 0) first = i;
                mism++;
            end
        end
        vectors++;
        if (mism != 0) begin
            miscompares++;
            $display("FAIL %s_stream: got %0d wrong bits (first at %0d) required 0", name, mism, first);
        end
        vectors++;
        if (done_step != last_bit_step + 1) begin
            miscompares++;
            $display("FAIL %s_done_timing: got done at %0d required %0d", name, done_step, last_bit_step + 1);
        end
        if (exp_done_step >= 0) begin
            vectors++;
            if (done_step != exp_done_step) begin
                miscompares++;
                $display("FAIL %s_done_step: got %0d required %0d", name, done_step, exp_done_step);
            end
        end
        vectors++;
        if (order_error !== exp_err) begin
            miscompares++;
            $display("FAIL %s_order_error: got %b required %b", name, order_error, exp_err);
        end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle_after: got done=%b busy=%b required 0 0", name, done, busy);
        end
        rec_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        logic [5:0] obs;
        obs = {term_ready, bit_valid, bit_data, busy, done, order_error};
        vectors++;
        if (obs !== 6'b0) begin
            miscompares++;
            $display("FAIL %s: got ready,valid,data,busy,done,err=%b required 000000", name, obs);
        end
    endtask

    task automatic load_full_zero();
        rec_t r;
        blk_q.delete();
        for (int i = 0; i < NR; i++) begin
            r.idx = 8'(i);
            r.en = '0;
            r.last = (i == NR - 1);
            blk_q.push_back(r);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b1;
        term_valid = 1'b1;
        term_index = '0;
        term_enable = '0;
        term_last = 1'b0;
        bit_ready = 1'b1;
        start_req = 1'b0;
        ready_mode = 0;
        stall_pend = 0;
        #12;
        check_reset_outputs("reset_outputs");
        @(negedge clock);
        reset_n = 1'b1;
        start = 1'b0;
        term_valid = 1'b0;
        #1;
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_full_block_with_start_spam();
        load_full_zero();
        ready_mode = 0;
        run_block("full_zero", 16000, NR * (NB + 1) + 2, 1'b1);
    endtask

    task automatic test_single_sparse();
        rec_t r;
        blk_q.delete();
        r.idx = 8'd7;
        r.en = '0;
        r.en[3] = 1'b1;
        r.last = 1'b1;
        blk_q.push_back(r);
        ready_mode = 0;
        run_block("sparse7", 16000, -1, 1'b0);
        vectors++;
        if (got_q.size() <= 619 || got_q[619] !== 1'b0 || got_q[618] !== 1'b1) begin
            miscompares++;
            $display("FAIL sparse7_bit619: got size=%0d bits618/619 wrong required 1/0", got_q.size());
        end
    endtask

    task automatic test_out_of_order_random();
        rec_t r;
        logic [95:0] t;
        int cur;
        blk_q.delete();
        foreach (t[i]) t[i] = 1'b0;
        t = {$urandom(), $urandom(), $urandom()};
        r.idx = 8'd5; r.en = t[NB-1:0]; r.last = 1'b0;
        blk_q.push_back(r);
        t = {$urandom(), $urandom(), $urandom()};
        r.idx = 8'd2; r.en = t[NB-1:0]; r.last = 1'b0;
        blk_q.push_back(r);
        cur = 6;
        while (cur < 150) begin
            t = {$urandom(), $urandom(), $urandom()};
            r.idx = 8'(cur); r.en = t[NB-1:0]; r.last = 1'b0;
            blk_q.push_back(r);
            if ($urandom_range(0, 7) == 0) begin
                r.idx = 8'(cur - 2);
                blk_q.push_back(r);
            end
            cur += $urandom_range(1, 4);
        end
        t = {$urandom(), $urandom(), $urandom()};
        r.idx = 8'(cur); r.en = t[NB-1:0]; r.last = 1'b1;
        blk_q.push_back(r);
        ready_mode = 2;
        run_block("random_order", 20000, -1, 1'b0);
    endtask

    task automatic test_reset_mid_then_stalled_restart();
        load_full_zero();
        rec_q = blk_q;
        got_q.delete();
        step_n = 0;
        ready_mode = 0;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        while (got_q.size() < 40 * NB + 10 && step_n < 5000) step();
        vectors++;
        if (got_q.size() < 40 * NB + 10 || bit_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reach_row40: got %0d bits valid=%b required %0d bits valid=1",
                     got_q.size(), bit_valid, 40 * NB + 10);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_outputs");
        @(negedge clock);
        reset_n = 1'b1;
        stall_pend = 0;
        rec_q.delete();
        load_full_zero();
        ready_mode = 1;
        run_block("restart_toggle", 32000, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_block_with_start_spam();
        test_single_sparse();
        test_out_of_order_random();
        test_reset_mid_then_stalled_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_term_configuration_encoder.md
PRODUCT_TERM_CONFIGURATION_ENCODER -- requirements
Module: product_term_configuration_encoder

Interface
REQ-001 SHALL have parameter num_labs, default 2, number of LABs in the device.
REQ-002 SHALL have parameter macrocells_per_lab, default 16, macrocells per LAB.
REQ-003 SHALL have parameter product_terms_per_macrocell, default 5, product terms per macrocell.
REQ-004 SHALL have parameter bits_per_product_term, default 88, configuration bits per product-term row.
REQ-005 SHALL derive num_rows = num_labs*macrocells_per_lab*product_terms_per_macrocell (default 160) and row_w = clog2(num_rows) (default 8).
REQ-006 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, pulse that begins one block encode.
REQ-009 SHALL have port term_valid, input, 1, product-term record offered.
REQ-010 SHALL have port term_ready, output, 1, record accepted this cycle when high with term_valid.
REQ-011 SHALL have port term_index, input, row_w, linear row = (lab-A)*80 + (macrocell-1)*5 + (product_term-1) at defaults.
REQ-012 SHALL have port term_enable, input, bits_per_product_term, input-signal enables for the row (1 = enabled).
REQ-013 SHALL have port term_last, input, 1, marks final record; rows after it are filled.
REQ-014 SHALL have port bit_valid, output, 1, serial bitstream bit present.
REQ-015 SHALL have port bit_ready, input, 1, downstream accepts bit.
REQ-016 SHALL have port bit_data, output, 1, bitstream bit.
REQ-017 SHALL have port busy, output, 1, encode in progress.
REQ-018 SHALL have port done, output, 1, one-cycle pulse after final bit accepted.
REQ-019 SHALL have port order_error, output, 1, sticky: record arrived with term_index below current row.

Function
REQ-020 SHALL encode row bit i as ~term_enable[i] (1 = input disabled, 0 = enabled).
REQ-021 SHALL emit rows in ascending row order, each row LSB first, so stream bit n maps to block offset n (row*bits_per_product_term + i).
REQ-022 SHALL use states IDLE, LOAD, SHIFT, DONE.
REQ-023 IDLE: start -> LOAD with row=0, bit=0, order_error cleared; start in any other state ignored.
REQ-024 LOAD, term_valid and term_index==row: term_ready=1, shift register <= encoded row, -> SHIFT.
REQ-025 LOAD, term_valid and term_index>row, or fill mode active: term_ready=0, shift register <= all ones, -> SHIFT.
REQ-026 LOAD, term_valid and term_index<row: term_ready=1, record discarded, order_error<=1, stay LOAD.
REQ-027 LOAD, no term_valid and not fill mode: wait, term_ready=0.
REQ-028 Accepting a record with term_last=1 SHALL set fill mode; also a term_last record discarded per REQ-026 sets fill mode.
REQ-029 term_ready SHALL be 0 in IDLE, SHIFT, DONE.
REQ-030 SHIFT: bit_valid=1, bit_data=shift register bit 0; on bit_ready shift right, bit++.
REQ-031 bit_valid SHALL rise the cycle after LOAD completes (one-cycle load latency); bit_data stable while bit_valid and !bit_ready.
REQ-032 On acceptance of bit bits_per_product_term-1: bit=0, row++; row==num_rows-1 -> DONE, else -> LOAD.
REQ-033 DONE: done=1 for one cycle, -> IDLE; total bits emitted = num_rows*bits_per_product_term (14080 at defaults).
REQ-034 busy SHALL be 1 in LOAD, SHIFT, DONE.
REQ-035 term_index >= num_rows SHALL be treated as greater than any row (fills to end, never accepted).

Reset
REQ-036 reset_n low SHALL immediately force IDLE, row=0, bit=0, fill mode=0, shift register=0, order_error=0.
REQ-037 Reset outputs: term_ready=0, bit_valid=0, bit_data=0, busy=0, done=0.
REQ-038 Reset mid-encode SHALL abandon the block; no resume.

Structure
REQ-039 Shared package SHALL hold default geometry constants, num_rows/row_w derivation, state enum, and a row-index function (lab, macrocell, product_term -> row).
REQ-040 One sub-module, product_term_row_serializer (load, shift, valid/ready, bit counter), is natural; control FSM stays at top.

Verification
REQ-041 start, records rows 0..159 all enable=0, bit_ready=1 -> 14080 ones, done after last bit, order_error=0.
REQ-042 Single record index 7, enable bit3=1 only, term_last=1 -> rows 0..6 all ones; row 7 bit3=0 (stream bit 619=0); rest ones.
REQ-043 Records index 5 then index 2 -> index 2 discarded, order_error=1, stream unaffected.
REQ-044 bit_ready toggled 1/0 every cycle -> bit_data held stable while stalled, identical stream to REQ-041 case.
REQ-045 reset_n pulsed low during row 40 -> outputs at reset values same cycle; new start restarts at stream bit 0.
REQ-046 start asserted while busy -> ignored, stream and done timing unchanged.
